mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- clear_in  in  1  pipeline flush
- inst_ask  in  1  instruction fetch request, from ICache
- inst_addr  in  32  fetch byte address
- inst_valid  out  1  fetch-done pulse
- inst_data  out  32  fetched word
- data_ask  in  1  load/store request, from LSB
- data_wr  in  1  1=store, 0=load
- data_len  in  2  00 byte, 01 half, 10 word
- data_addr  in  32  byte address
- data_wdata  in  32  store data, low bytes used
- data_valid  out  1  load/store-done pulse
- data_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe

Function
REQ-002 SHALL implement states IDLE, BUSY, DONE.
REQ-003 IDLE SHALL accept a request at a clock edge E0; data_ask has priority over inst_ask when both are high; no preemption once BUSY.
REQ-004 Byte count N SHALL be 4 for fetches, and 1/2/4 per data_len for data requests; data_len=11 SHALL be treated as 4.
REQ-005 Read: mem_a SHALL equal addr+i from edge Ei, i=0..N-1; RAM byte i SHALL be captured from mem_din at edge E(i+2) into bits [8i+7:8i], little-endian.
REQ-006 Read: the valid/data output SHALL be set at edge E(N+1), so that a fetch pulses inst_valid at E5.
REQ-007 Write: mem_wr=1, mem_a=addr+i, mem_dout=wdata[8i+7:8i] SHALL be driven from edge Ei, i=0..N-1; data_valid SHALL be set at edge EN; mem_wr SHALL be 0 otherwise.
REQ-008 Address arithmetic SHALL be 32-bit modulo 2^32; wrap at 0xFFFFFFFF SHALL be silent.
REQ-009 inst_valid/data_valid SHALL be high for exactly one cycle; that cycle is DONE.
REQ-010 DONE SHALL ignore all requests and return to IDLE, giving the requester one cycle to drop its ask.
REQ-011 Requesters SHALL hold ask/addr/len/wdata stable until valid; mid-transaction changes SHALL be ignored, because operands are latched at E0.
REQ-012 inst_data/data_rdata SHALL hold their last value until the next completion.
REQ-013 clear_in high at an edge SHALL abort any BUSY read of either port with no valid pulse, return to IDLE, and cancel a valid being set on the same edge.
REQ-014 clear_in SHALL never abort a write; a write in progress SHALL complete.
REQ-015 clear_in in IDLE SHALL block acceptance at that edge.
REQ-016 rdy_in low SHALL hold state, counters, and outputs, and SHALL force mem_wr=0.
REQ-017 A read's mem_a SHALL idle at its last address; no spurious mem_wr SHALL occur.

Reset
REQ-018 rst_in high SHALL immediately set state=IDLE, counters=0, mem_a=0, mem_dout=0, mem_wr=0, inst_valid=0, data_valid=0, inst_data=0, data_rdata=0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no valid pulse; the first request after release SHALL be accepted normally.

Configuration
REQ-020 With macro IO_BUFFER_FULL_EN defined, the block SHALL add input io_buffer_full (1 bit).
REQ-021 With IO_BUFFER_FULL_EN defined, a write byte to address 0x30000 or 0x30004 SHALL be held (mem_wr=0, counter frozen) while io_buffer_full=1, and SHALL issue on the first edge it is 0.
REQ-022 Without IO_BUFFER_FULL_EN, the port SHALL be absent and writes SHALL never stall.

Structure
REQ-023 State encodings and data_len codes SHALL be defined in the shared const.v.
REQ-024 The block SHALL be a single module; no sub-module.

Verification
REQ-025 Fetch from 0x1000 with RAM bytes 13,05,00,00 -> inst_valid pulses at E5 with inst_data=0x00000513; the next cycle is DONE, then IDLE.
REQ-026 Same-edge inst_ask@0x0 and data_ask load word@0x20 -> data served first with data_valid; the fetch is accepted after DONE.
REQ-027 Store half 0xABCD to 0x100 -> mem_wr high 2 cycles: (0x100,CD), (0x101,AB); data_valid at E2.
REQ-028 clear_in asserted at E3 of a fetch -> no inst_valid, state IDLE; a store in flight with clear_in -> completes with all bytes written.
REQ-029 rst_in pulsed asynchronously mid-load -> outputs zero at once, no data_valid; a new fetch afterward returns the correct word.
REQ-030 With IO_BUFFER_FULL_EN, store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those cycles, then one write; data_valid follows.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder. This package holds the
// controller state encodings, the data_len size codes, the memory-mapped
// I/O addresses that can back-pressure stores, and small byte helpers.
// It has no ports.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0]  LEN_BYTE = 2'b00;
    localparam logic [1:0]  LEN_HALF = 2'b01;
    localparam logic [1:0]  LEN_WORD = 2'b10;

    localparam logic [31:0] IO_ADDR_A = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_B = 32'h0003_0004;

    // Bytes moved for a data request; the reserved code 11 is a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            LEN_WORD: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    // Little-endian byte lane select.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic is_io_addr(input logic [31:0] a);
        return (a == IO_ADDR_A) || (a == IO_ADDR_B);
    endfunction

endpackage

// File: rtl/mem_responder.sv
// mem_responder
// Byte-serial RAM front end shared by the instruction fetch port and the
// load/store port. A request is accepted in IDLE (data wins over fetch), its
// operands are latched, the bytes are walked out over the 8-bit RAM bus in
// BUSY, and completion is signalled by a one-cycle valid pulse in DONE.
// RAM reads have one cycle of latency: byte i is addressed at edge Ei and
// captured at edge E(i+2).
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global freeze), clear_in (flush)
//   inst_ask/inst_addr -> inst_valid/inst_data       fetch port (always 4 bytes)
//   data_ask/data_wr/data_len/data_addr/data_wdata -> data_valid/data_rdata
//   mem_din, mem_dout, mem_a, mem_wr                 byte-wide RAM bus
//   io_buffer_full                                   only with IO_BUFFER_FULL_EN
//
// Build option: define IO_BUFFER_FULL_EN to add io_buffer_full, which holds
// store bytes aimed at the I/O addresses 0x30000/0x30004 while it is high.
module mem_responder
    import mem_responder_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        inst_ask,
    input  logic [31:0] inst_addr,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    input  logic        data_ask,
    input  logic        data_wr,
    input  logic [1:0]  data_len,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_valid,
    output logic [31:0] data_rdata,
`ifdef IO_BUFFER_FULL_EN
    input  logic        io_buffer_full,
`endif
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_e      state_r, state_next;
    logic [2:0]  cnt_r, cnt_next;        // edge index in a read, next byte index in a write
    logic [2:0]  n_r, n_next;
    logic [31:0] addr_r, addr_next;
    logic [31:0] wdata_r, wdata_next;
    logic        is_data_r, is_data_next;
    logic        is_wr_r, is_wr_next;
    logic [23:0] rbuf_r, rbuf_next;      // bytes 0..2; the last byte comes straight from mem_din
    logic [31:0] mem_a_r, mem_a_next;
    logic [7:0]  mem_dout_r, mem_dout_next;
    logic        mem_wr_r, mem_wr_next;
    logic        inst_valid_r, inst_valid_next;
    logic [31:0] inst_data_r, inst_data_next;
    logic        data_valid_r, data_valid_next;
    logic [31:0] data_rdata_r, data_rdata_next;

    logic [31:0] accept_addr_s;
    logic [2:0]  accept_n_s;
    logic        accept_wr_s;
    logic [31:0] cur_addr_s;
    logic        io_full_s;
    logic        accept_stall_s;
    logic        busy_stall_s;
    logic [31:0] rd_word_s;

`ifdef IO_BUFFER_FULL_EN
    assign io_full_s = io_buffer_full;
`else
    assign io_full_s = 1'b0;
`endif

    assign accept_addr_s  = data_ask ? data_addr : inst_addr;
    assign accept_n_s     = data_ask ? byte_count(data_len) : 3'd4;
    assign accept_wr_s    = data_ask & data_wr;
    assign cur_addr_s     = addr_r + {29'd0, cnt_r};     // wraps silently mod 2^32
    assign accept_stall_s = io_full_s & is_io_addr(accept_addr_s);
    assign busy_stall_s   = io_full_s & is_io_addr(cur_addr_s);

    // Assemble the completed read word, zero-extended to 32 bits.
    always_comb begin
        rd_word_s = 32'd0;
        case (n_r)
            3'd1:    rd_word_s = {24'd0, mem_din};
            3'd2:    rd_word_s = {16'd0, mem_din, rbuf_r[7:0]};
            default: rd_word_s = {mem_din, rbuf_r};
        endcase
    end

    // Next-state and datapath decode for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_next      = state_r;
        cnt_next        = cnt_r;
        n_next          = n_r;
        addr_next       = addr_r;
        wdata_next      = wdata_r;
        is_data_next    = is_data_r;
        is_wr_next      = is_wr_r;
        rbuf_next       = rbuf_r;
        mem_a_next      = mem_a_r;
        mem_dout_next   = mem_dout_r;
        mem_wr_next     = 1'b0;
        inst_valid_next = 1'b0;
        inst_data_next  = inst_data_r;
        data_valid_next = 1'b0;
        data_rdata_next = data_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (!clear_in && (data_ask || inst_ask)) begin
                    state_next   = ST_BUSY;
                    n_next       = accept_n_s;
                    addr_next    = accept_addr_s;
                    wdata_next   = data_wdata;
                    is_data_next = data_ask;
                    is_wr_next   = accept_wr_s;
                    rbuf_next    = 24'd0;
                    mem_a_next   = accept_addr_s;
                    if (accept_wr_s && !accept_stall_s) begin
                        mem_wr_next   = 1'b1;
                        mem_dout_next = data_wdata[7:0];
                        cnt_next      = 3'd1;
                    end else if (accept_wr_s) begin
                        cnt_next = 3'd0;        // byte 0 held by the I/O buffer
                    end else begin
                        cnt_next = 3'd1;
                    end
                end else begin
                    cnt_next = 3'd0;
                end
            end
            ST_BUSY: begin
                if (is_wr_r) begin
                    // Writes ignore clear_in and always run to completion.
                    if (cnt_r == n_r) begin
                        state_next      = ST_DONE;
                        data_valid_next = 1'b1;
                        cnt_next        = 3'd0;
                    end else if (busy_stall_s) begin
                        cnt_next = cnt_r;
                    end else begin
                        mem_wr_next   = 1'b1;
                        mem_a_next    = cur_addr_s;
                        mem_dout_next = get_byte(wdata_r, cnt_r[1:0]);
                        cnt_next      = cnt_r + 3'd1;
                    end
                end else if (clear_in) begin
                    state_next = ST_IDLE;
                    cnt_next   = 3'd0;
                end else if (cnt_r == n_r + 3'd1) begin
                    state_next = ST_DONE;
                    cnt_next   = 3'd0;
                    if (is_data_r) begin
                        data_valid_next = 1'b1;
                        data_rdata_next = rd_word_s;
                    end else begin
                        inst_valid_next = 1'b1;
                        inst_data_next  = rd_word_s;
                    end
                end else begin
                    // Address stays parked on the last byte once all are issued.
                    if (cnt_r < n_r) begin
                        mem_a_next = cur_addr_s;
                    end else begin
                        mem_a_next = mem_a_r;
                    end
                    case (cnt_r)
                        3'd2:    rbuf_next[7:0]   = mem_din;
                        3'd3:    rbuf_next[15:8]  = mem_din;
                        3'd4:    rbuf_next[23:16] = mem_din;
                        default: rbuf_next        = rbuf_r;
                    endcase
                    cnt_next = cnt_r + 3'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_next   = 3'd0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Controller state register; rdy_in low freezes it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else if (rdy_in) begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
        end
    end

    // Latched operands, read buffer and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            n_r          <= 3'd0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            is_data_r    <= 1'b0;
            is_wr_r      <= 1'b0;
            rbuf_r       <= 24'd0;
            mem_a_r      <= 32'd0;
            mem_dout_r   <= 8'd0;
            mem_wr_r     <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_data_r  <= 32'd0;
            data_valid_r <= 1'b0;
            data_rdata_r <= 32'd0;
        end else if (rdy_in) begin
            n_r          <= n_next;
            addr_r       <= addr_next;
            wdata_r      <= wdata_next;
            is_data_r    <= is_data_next;
            is_wr_r      <= is_wr_next;
            rbuf_r       <= rbuf_next;
            mem_a_r      <= mem_a_next;
            mem_dout_r   <= mem_dout_next;
            mem_wr_r     <= mem_wr_next;
            inst_valid_r <= inst_valid_next;
            inst_data_r  <= inst_data_next;
            data_valid_r <= data_valid_next;
            data_rdata_r <= data_rdata_next;
        end
    end

    // The strobe is masked while frozen so a held write byte is not repeated.
    assign mem_wr     = mem_wr_r & rdy_in;
    assign mem_a      = mem_a_r;
    assign mem_dout   = mem_dout_r;
    assign inst_valid = inst_valid_r;
    assign inst_data  = inst_data_r;
    assign data_valid = data_valid_r;
    assign data_rdata = data_rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder with a byte-wide RAM model (one-cycle
// read latency, 256 KiB aliased by address bits [17:0]).
module tb_mem_responder;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        inst_ask;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        data_ask, data_wr;
    logic [1:0]  data_len;
    logic [31:0] data_addr, data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef IO_BUFFER_FULL_EN
    logic        io_buffer_full;
`endif

    logic [7:0]  ram [0:262143];
    logic        poke_en;
    logic [17:0] poke_a;
    logic [7:0]  poke_d;
    int          wr_cnt = 0;
    int          iv_cnt = 0;
    int          dv_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          iv0, dv0, wc0;

    mem_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .inst_ask(inst_ask), .inst_addr(inst_addr),
        .inst_valid(inst_valid), .inst_data(inst_data),
        .data_ask(data_ask), .data_wr(data_wr), .data_len(data_len),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_valid(data_valid), .data_rdata(data_rdata),
`ifdef IO_BUFFER_FULL_EN
        .io_buffer_full(io_buffer_full),
`endif
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: registered read, write on strobe, bench preload port.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[17:0]];
        if (poke_en) begin
            ram[poke_a] <= poke_d;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Count cycles in which each valid is high.
    always @(negedge clk_in) begin
        if (inst_valid) iv_cnt <= iv_cnt + 1;
        if (data_valid) dv_cnt <= dv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        poke_a = a; poke_d = d; poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic data_req(input logic wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
        data_ask = 1'b1; data_wr = wr; data_len = len; data_addr = a; data_wdata = wd;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; poke_en = 1'b0;
        poke_a = 18'd0; poke_d = 8'd0;
        inst_ask = 1'b0; inst_addr = 32'd0;
        data_ask = 1'b0; data_wr = 1'b0; data_len = 2'b00; data_addr = 32'd0; data_wdata = 32'd0;
`ifdef IO_BUFFER_FULL_EN
        io_buffer_full = 1'b0;
`endif
        poke(18'h01000, 8'h13); poke(18'h01001, 8'h05); poke(18'h01002, 8'h00); poke(18'h01003, 8'h00);
        poke(18'h00000, 8'h93); poke(18'h00001, 8'h00); poke(18'h00002, 8'h10); poke(18'h00003, 8'h00);
        poke(18'h00020, 8'h11); poke(18'h00021, 8'h22); poke(18'h00022, 8'h33); poke(18'h00023, 8'h44);
        poke(18'h3FFFF, 8'h77); poke(18'h00102, 8'h5A);
        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("rst_valids", {30'd0, inst_valid, data_valid}, 32'd0);
        check_eq("rst_inst_data", inst_data, 32'd0);
        rst_in = 1'b0;
        tick();

        // Fetch 0x1000 -> 0x00000513 at E5, then DONE for one cycle.
        inst_ask = 1'b1; inst_addr = 32'h0000_1000; iv0 = iv_cnt;
        tick();
        check_eq("fetch_a_e0", mem_a, 32'h0000_1000);
        ticks(3);
        check_eq("fetch_a_e3", mem_a, 32'h0000_1003);
        tick();
        check_eq("fetch_nv_e4", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("fetch_v_e5", {31'd0, inst_valid}, 32'd1);
        check_eq("fetch_data", inst_data, 32'h0000_0513);
        inst_ask = 1'b0;
        tick();
        check_eq("fetch_v_e6", {31'd0, inst_valid}, 32'd0);
        check_eq("fetch_pulse", iv_cnt - iv0, 32'd1);

        // Data beats fetch on the same edge; fetch follows after DONE.
        inst_ask = 1'b1; inst_addr = 32'd0;
        data_req(1'b0, 2'b10, 32'h0000_0020, 32'd0);
        tick();
        check_eq("prio_a_e0", mem_a, 32'h0000_0020);
        ticks(4);
        tick();
        check_eq("prio_dv", {30'd0, data_valid, inst_valid}, 32'd2);
        check_eq("prio_rdata", data_rdata, 32'h4433_2211);
        data_ask = 1'b0;
        tick();
        check_eq("prio_dv_off", {31'd0, data_valid}, 32'd0);
        tick();
        check_eq("prio_fetch_a", mem_a, 32'd0);
        ticks(4);
        check_eq("prio_iv_e4", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("prio_iv_e5", {31'd0, inst_valid}, 32'd1);
        check_eq("prio_idata", inst_data, 32'h0010_0093);
        inst_ask = 1'b0;
        tick();

        // Store half 0xABCD at 0x100.
        wc0 = wr_cnt;
        data_req(1'b1, 2'b01, 32'h0000_0100, 32'h1234_ABCD);
        tick();
        check_eq("sh_e0", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h00, 8'hCD});
        tick();
        check_eq("sh_e1", {mem_wr, data_valid, 14'd0, mem_a[7:0], mem_dout}, {1'b1, 1'b0, 14'd0, 8'h01, 8'hAB});
        tick();
        check_eq("sh_e2", {30'd0, mem_wr, data_valid}, 32'd1);
        data_ask = 1'b0;
        tick();
        check_eq("sh_ram", {8'd0, ram[18'h102], ram[18'h101], ram[18'h100]}, 32'h005A_ABCD);
        check_eq("sh_wr_cnt", wr_cnt - wc0, 32'd2);

        // clear_in at E3 of a fetch aborts it silently.
        inst_ask = 1'b1; inst_addr = 32'h0000_1000; iv0 = iv_cnt;
        ticks(3);
        clear_in = 1'b1; inst_ask = 1'b0;
        tick();
        clear_in = 1'b0;
        ticks(3);
        check_eq("clr_no_iv", iv_cnt - iv0, 32'd0);
        check_eq("clr_hold_data", inst_data, 32'h0010_0093);

        // clear_in blocks acceptance in IDLE but never aborts a store.
        wc0 = wr_cnt; dv0 = dv_cnt;
        data_req(1'b1, 2'b10, 32'h0000_0200, 32'hDEAD_BEEF);
        clear_in = 1'b1;
        tick();
        check_eq("clr_block", {31'd0, mem_wr}, 32'd0);
        clear_in = 1'b0;
        tick();
        check_eq("sw_e0", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h00, 8'hEF});
        clear_in = 1'b1;
        ticks(3);
        check_eq("sw_e3", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h03, 8'hDE});
        tick();
        check_eq("sw_e4", {30'd0, mem_wr, data_valid}, 32'd1);
        data_ask = 1'b0; clear_in = 1'b0;
        tick();
        check_eq("sw_ram", {ram[18'h203], ram[18'h202], ram[18'h201], ram[18'h200]}, 32'hDEAD_BEEF);
        check_eq("sw_wr_cnt", wr_cnt - wc0, 32'd4);

        // Byte load zero-extends; len=11 behaves as a word.
        data_req(1'b0, 2'b00, 32'h0000_0023, 32'd0);
        ticks(2);
        check_eq("lb_nv_e1", {31'd0, data_valid}, 32'd0);
        tick();
        check_eq("lb_v_e2", {31'd0, data_valid}, 32'd1);
        check_eq("lb_data", data_rdata, 32'h0000_0044);
        data_ask = 1'b0;
        tick();
        data_req(1'b0, 2'b11, 32'h0000_1000, 32'd0);
        ticks(5);
        check_eq("l11_nv_e4", {31'd0, data_valid}, 32'd0);
        tick();
        check_eq("l11_data", {data_valid, data_rdata[30:0]}, 32'h8000_0513);
        data_ask = 1'b0;
        tick();

        // Half load across the top of the address space.
        data_req(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0);
        tick();
        check_eq("wrap_a_e0", mem_a, 32'hFFFF_FFFF);
        tick();
        check_eq("wrap_a_e1", mem_a, 32'h0000_0000);
        ticks(2);
        check_eq("wrap_data", {data_valid, data_rdata[30:0]}, 32'h8000_9377);
        data_ask = 1'b0;
        tick();

        // rdy_in low freezes a store and masks the strobe.
        wc0 = wr_cnt;
        data_req(1'b1, 2'b00, 32'h0000_0300, 32'h0000_0041);
        tick();
        check_eq("rdy_e0", {31'd0, mem_wr}, 32'd1);
        rdy_in = 1'b0;
        #1;
        check_eq("rdy_force", {31'd0, mem_wr}, 32'd0);
        tick();
        check_eq("rdy_hold", {mem_wr, data_valid, 14'd0, mem_a[15:0]}, 32'h0000_0300);
        rdy_in = 1'b1;
        tick();
        check_eq("rdy_done", {31'd0, data_valid}, 32'd1);
        data_ask = 1'b0;
        tick();
        check_eq("rdy_ram", {24'd0, ram[18'h300]}, 32'h0000_0041);
        check_eq("rdy_wr_cnt", wr_cnt - wc0, 32'd1);

        // Asynchronous reset mid-load, then a clean fetch.
        dv0 = dv_cnt;
        data_req(1'b0, 2'b10, 32'h0000_0020, 32'd0);
        ticks(3);
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("arst_rdata", data_rdata, 32'd0);
        check_eq("arst_idata", inst_data, 32'd0);
        check_eq("arst_mem_a", mem_a, 32'd0);
        data_ask = 1'b0;
        tick();
        rst_in = 1'b0;
        ticks(6);
        check_eq("arst_no_dv", dv_cnt - dv0, 32'd0);
        inst_ask = 1'b1; inst_addr = 32'h0000_1000;
        ticks(6);
        check_eq("arst_fetch", {inst_valid, inst_data[30:0]}, 32'h8000_0513);
        inst_ask = 1'b0;
        tick();

`ifdef IO_BUFFER_FULL_EN
        // Store to the I/O address waits out io_buffer_full.
        wc0 = wr_cnt;
        io_buffer_full = 1'b1;
        data_req(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("io_hold", {31'd0, mem_wr}, 32'd0);
        end
        io_buffer_full = 1'b0;
        tick();
        check_eq("io_issue", {mem_wr, 7'd0, mem_a[23:0]}, 32'h8003_0000);
        check_eq("io_dout", {24'd0, mem_dout}, 32'h0000_0041);
        tick();
        check_eq("io_dv", {30'd0, mem_wr, data_valid}, 32'd1);
        data_ask = 1'b0;
        tick();
        check_eq("io_wr_cnt", wr_cnt - wc0, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
